// File: rtl/product_accumulator.sv
// Saturating MAC back end: sums a programmed number of signed products and
// presents the result on a valid/ready output that is held until accepted.
module product_accumulator #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 64,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_sat,
    output logic              busy,
    output logic [LEN_W-1:0]  term_cnt
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t            state, next_state;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  sum_q;
    logic [LEN_W-1:0]  len_q;
    logic              sat_q;
    logic              xfer;
    logic              last;
    logic [ACC_W:0]    wide_sum;
    logic [ACC_W-1:0]  sat_val;
    logic              ovf;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    assign xfer = (state == ACCUM) && in_valid;
    assign last = (term_cnt == len_q - LEN_W'(1));

    // One extra bit of headroom: overflow shows up as the top two bits differing.
    always_comb begin
        wide_sum = {acc[ACC_W-1], acc}
                 + {{(ACC_W-PROD_W+1){in_data[PROD_W-1]}}, in_data};
        ovf      = wide_sum[ACC_W] != wide_sum[ACC_W-1];
        if (!ovf)
            sat_val = wide_sum[ACC_W-1:0];
        else if (wide_sum[ACC_W])
            sat_val = ACC_MIN;
        else
            sat_val = ACC_MAX;
    end

    always_ff @(posedge clk) begin
        if (rst || clear)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (len == '0) ? HOLD : ACCUM;
            ACCUM:   if (xfer && last) next_state = HOLD;
            HOLD:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE:    busy = 1'b0;
            ACCUM:   in_ready = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // sum_q is loaded only when a result is produced, so clear leaves the
    // last delivered value visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            sum_q    <= '0;
            len_q    <= '0;
            sat_q    <= 1'b0;
            term_cnt <= '0;
        end else if (clear) begin
            acc      <= '0;
            len_q    <= '0;
            sat_q    <= 1'b0;
            term_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc      <= '0;
                    sat_q    <= 1'b0;
                    term_cnt <= '0;
                    len_q    <= len;
                    if (len == '0) sum_q <= '0;
                end
                ACCUM: if (xfer) begin
                    acc      <= sat_val;
                    term_cnt <= term_cnt + LEN_W'(1);
                    if (ovf) sat_q <= 1'b1;
                    if (last) sum_q <= sat_val;
                end
                default: ;
            endcase
        end
    end

    assign out_sum = sum_q;
    assign out_sat = sat_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator with hand-computed expectations.
module tb_product_accumulator;

    localparam int PROD_W = 64;
    localparam int ACC_W  = 64;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst, start, clear, in_valid, out_ready;
    logic [LEN_W-1:0]  len;
    logic [PROD_W-1:0] in_data;
    logic              in_ready, out_valid, out_sat, busy;
    logic [ACC_W-1:0]  out_sum;
    logic [LEN_W-1:0]  term_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_sat(out_sat), .busy(busy), .term_cnt(term_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [LEN_W-1:0] n);
        start = 1'b1; len = n;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input logic [63:0] d);
        in_valid = 1'b1; in_data = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; clear = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; len = '0; in_data = '0;
        step();
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sum", out_sum, 64'd0);
        chk("rst_cnt", 64'(term_cnt), 64'd0);

        // Basic three-term sum
        kick(8'd3);
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        feed(-64'sd1500);
        feed(64'sd100);
        chk("t1_no_early_valid", 64'(out_valid), 64'd0);
        feed(64'sd1500);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_sum", out_sum, 64'd100);
        chk("t1_sat", 64'(out_sat), 64'd0);
        chk("t1_cnt", 64'(term_cnt), 64'd3);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_done_valid", 64'(out_valid), 64'd0);

        // Gaps on the input and backpressure on the output
        kick(8'd2);
        feed(64'sd10);
        for (int i = 0; i < 3; i++) step();
        chk("t2_gap_cnt", 64'(term_cnt), 64'd1);
        chk("t2_gap_valid", 64'(out_valid), 64'd0);
        feed(64'sd22);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 64'(out_valid), 64'd1);
            chk("t2_hold_sum", out_sum, 64'd32);
            chk("t2_hold_in_ready", 64'(in_ready), 64'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t2_idle_valid", 64'(out_valid), 64'd0);
        chk("t2_idle_busy", 64'(busy), 64'd0);

        // Positive saturation, then recovery on a fresh run
        kick(8'd3);
        feed(64'h7FFF_FFFF_FFFF_FFFF);
        feed(64'd1);
        feed(-64'sd1);
        chk("t3_sum", out_sum, 64'h7FFF_FFFF_FFFF_FFFE);
        chk("t3_sat", 64'(out_sat), 64'd1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        kick(8'd1);
        feed(64'sd8);
        chk("t3b_sum", out_sum, 64'd8);
        chk("t3b_sat", 64'(out_sat), 64'd0);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // Negative saturation
        kick(8'd2);
        feed(64'h8000_0000_0000_0000);
        feed(-64'sd5);
        chk("t3c_sum", out_sum, 64'h8000_0000_0000_0000);
        chk("t3c_sat", 64'(out_sat), 64'd1);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // Zero-length run
        kick(8'd0);
        chk("t4_valid", 64'(out_valid), 64'd1);
        chk("t4_sum", out_sum, 64'd0);
        chk("t4_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("t4_idle", 64'(busy), 64'd0);

        // Abort mid-run; out_sum keeps last delivered value (0)
        kick(8'd4);
        feed(64'sd7);
        feed(64'sd9);
        clear = 1'b1; in_valid = 1'b1; in_data = 64'sd3;
        step();
        clear = 1'b0; in_valid = 1'b0;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_cnt", 64'(term_cnt), 64'd0);
        chk("t5_sum_kept", out_sum, 64'd0);
        step();
        chk("t5_no_valid", 64'(out_valid), 64'd0);
        kick(8'd1);
        feed(-64'sd22500);
        chk("t5_new_valid", 64'(out_valid), 64'd1);
        chk("t5_new_sum", out_sum, -64'sd22500);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // start and clear together: clear wins
        start = 1'b1; clear = 1'b1; len = 8'd2;
        step();
        start = 1'b0; clear = 1'b0;
        chk("t7_busy", 64'(busy), 64'd0);

        // Clear on the final transfer discards the result
        kick(8'd1);
        clear = 1'b1; in_valid = 1'b1; in_data = 64'sd44;
        step();
        clear = 1'b0; in_valid = 1'b0;
        chk("t8_valid", 64'(out_valid), 64'd0);
        chk("t8_sum", out_sum, -64'sd22500);

        // Reset while holding a result
        kick(8'd1);
        feed(64'sd5);
        chk("t6_pre_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_sum", out_sum, 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
